fetch_pc_unit: RTL and testbench

- Program-counter register and instruction-fetch sequencer that sits directly downstream of the 32-bit next-PC 2:1 select (i1 = sequential PC, i2 = branch/jump target, s = redirect).
- Its pc_plus4 output drives the select's i1 input. The select's output returns as next_pc, and this block loads it into the PC.
- Issues requests on the instruction-memory req/gnt/rvalid interface and presents a valid/ready instruction to decode.

---
 rtl/fetch_pc_unit.sv | 169 ++++++++++++++++
 tb/tb_fetch_pc_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: program-counter register and instruction-fetch sequencer.
// It holds the PC, exports pc+4 to the external next-PC select, and runs the
// imem req/gnt/rvalid handshake. The fetched word is presented to decode
// with a valid/ready handshake. A flush redirects the PC from any non-idle
// state. Any response that is still outstanding is discarded through a kill flag.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned-PC trap state
// plus a misalign_err output). Without it, the low PC bits are cleared on load.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] next_pc,
  input  logic        flush,
  output logic [31:0] pc_plus4,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        instr_valid,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic        misalign_err,
`endif
  input  logic        instr_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
`ifdef FETCH_MISALIGN_TRAP_EN
    S_HOLD,
    S_ERR
`else
    S_HOLD
`endif
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_kill;
  logic [31:0] r_instr;
  logic [31:0] r_pc_out;
  logic        r_valid;

  state_t      w_state;
  logic [31:0] w_pc;
  logic        w_kill;
  logic [31:0] w_instr;
  logic [31:0] w_pc_out;
  logic        w_valid;

  // A PC load either keeps the value as-is (so that the trap can see it) or clears the byte offset.
  function automatic logic [31:0] f_load_pc(input logic [31:0] v);
`ifdef FETCH_MISALIGN_TRAP_EN
    return v;
`else
    return {v[31:2], v[1:0] & 2'b00};
`endif
  endfunction

  // Next-state and next-data selection; flush outranks every other event outside IDLE.
  always_comb begin
    w_state  = r_state;
    w_pc     = r_pc;
    w_kill   = r_kill;
    w_instr  = r_instr;
    w_pc_out = r_pc_out;
    w_valid  = r_valid;
    case (r_state)
      S_IDLE: begin
        w_state = S_REQ;
      end
      S_REQ: begin
        if (flush) begin
          w_pc = f_load_pc(next_pc);
          if (imem_gnt) begin
            // The granted request still returns data; drop it when it arrives.
            w_state = S_WAIT;
            w_kill  = 1'b1;
          end
        end else if (imem_gnt) begin
          w_state = S_WAIT;
        end
      end
      S_WAIT: begin
        if (flush) begin
          w_pc = f_load_pc(next_pc);
          if (imem_rvalid) begin
            w_kill  = 1'b0;
            w_state = S_REQ;
          end else begin
            w_kill = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (r_kill) begin
            w_kill  = 1'b0;
            w_state = S_REQ;
          end else begin
            w_instr  = imem_rdata;
            w_pc_out = r_pc;
            w_valid  = 1'b1;
            w_state  = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        // flush and ready together still load the PC only once.
        if (flush || instr_ready) begin
          w_pc    = f_load_pc(next_pc);
          w_valid = 1'b0;
          w_instr = NOP_INSTR;
          w_state = S_REQ;
        end
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      S_ERR: begin
        if (flush) begin
          w_pc    = f_load_pc(next_pc);
          w_state = S_REQ;
        end
      end
`endif
      default: begin
        w_state = S_IDLE;
      end
    endcase
`ifdef FETCH_MISALIGN_TRAP_EN
    // Trap instead of issuing a fetch from a misaligned PC.
    if (w_state == S_REQ && w_pc[1:0] != 2'b00) begin
      w_state = S_ERR;
    end
`endif
  end

  // State and datapath registers, all cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_kill   <= 1'b0;
      r_instr  <= NOP_INSTR;
      r_pc_out <= RESET_PC;
      r_valid  <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_pc     <= w_pc;
      r_kill   <= w_kill;
      r_instr  <= w_instr;
      r_pc_out <= w_pc_out;
      r_valid  <= w_valid;
    end
  end

  assign pc_plus4    = r_pc + 32'd4;
  assign imem_req    = (r_state == S_REQ);
  assign imem_addr   = r_pc;
  assign instr_out   = r_instr;
  assign pc_out      = r_pc_out;
  assign instr_valid = r_valid;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign misalign_err = (r_state == S_ERR);
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed testbench for fetch_pc_unit. The bench models the external next-PC
// select as next_pc = flush ? tgt : pc_plus4.
`timescale 1ns/1ps
module tb_fetch_pc_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] next_pc;
  logic        flush;
  logic [31:0] pc_plus4;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] tgt;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign next_pc = flush ? tgt : pc_plus4;

  fetch_pc_unit dut (
    .clk(clk), .rst_n(rst_n), .next_pc(next_pc), .flush(flush),
    .pc_plus4(pc_plus4), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_out(instr_out), .pc_out(pc_out), .instr_valid(instr_valid),
`ifdef FETCH_MISALIGN_TRAP_EN
    .misalign_err(misalign_err),
`endif
    .instr_ready(instr_ready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    flush = 0; imem_gnt = 0; imem_rvalid = 0; imem_rdata = 32'h0;
    instr_ready = 0; tgt = 32'h0;
  endtask

  task automatic test_reset();
    rst_n = 0; clear_inputs();
    step(); step(); step();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %0b exp 0", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", instr_valid); end
    checks++; if (instr_out !== NOP) begin errors++; $display("FAIL reset_instr got %h exp %h", instr_out, NOP); end
    checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc_out got %h exp 0", pc_out); end
    checks++; if (pc_plus4 !== 32'h4) begin errors++; $display("FAIL reset_pc_plus4 got %h exp 4", pc_plus4); end
    rst_n = 1;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL idle_req got %0b exp 0", imem_req); end
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL first_req got req=%0b addr=%h exp req=1 addr=0", imem_req, imem_addr); end
  endtask

  task automatic test_basic_fetch();
    imem_gnt = 1; step(); imem_gnt = 0;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL wait_req got %0b exp 0", imem_req); end
    imem_rvalid = 1; imem_rdata = 32'h0050_0093; step(); imem_rvalid = 0;
    checks++; if (instr_valid !== 1'b1 || instr_out !== 32'h0050_0093 || pc_out !== 32'h0) begin
      errors++; $display("FAIL hold_data got v=%0b i=%h pc=%h exp v=1 i=00500093 pc=0", instr_valid, instr_out, pc_out); end
    instr_ready = 1; step(); instr_ready = 0;
    checks++; if (instr_valid !== 1'b0 || instr_out !== NOP) begin errors++; $display("FAIL after_ready got v=%0b i=%h exp v=0 i=%h", instr_valid, instr_out, NOP); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL next_addr got req=%0b addr=%h exp req=1 addr=4", imem_req, imem_addr); end
  endtask

  task automatic test_hold_stall();
    imem_gnt = 1; step(); imem_gnt = 0;
    imem_rvalid = 1; imem_rdata = 32'h0010_0113; step(); imem_rvalid = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (instr_valid !== 1'b1 || instr_out !== 32'h0010_0113 || pc_out !== 32'h4 || imem_req !== 1'b0) begin
        errors++; $display("FAIL stall_%0d got v=%0b i=%h pc=%h req=%0b exp v=1 i=00100113 pc=4 req=0", i, instr_valid, instr_out, pc_out, imem_req); end
    end
    instr_ready = 1; step(); instr_ready = 0;
    checks++; if (imem_addr !== 32'h8 || instr_valid !== 1'b0) begin errors++; $display("FAIL stall_release got addr=%h v=%0b exp addr=8 v=0", imem_addr, instr_valid); end
    step();
    checks++; if (imem_addr !== 32'h8 || imem_req !== 1'b1) begin errors++; $display("FAIL single_advance got addr=%h req=%0b exp addr=8 req=1", imem_addr, imem_req); end
  endtask

  task automatic test_flush_wait();
    imem_gnt = 1; step(); imem_gnt = 0;
    flush = 1; tgt = 32'h100; step(); flush = 0;
    checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h100) begin errors++; $display("FAIL flush_wait got req=%0b addr=%h exp req=0 addr=100", imem_req, imem_addr); end
    imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF; step(); imem_rvalid = 0;
    checks++; if (instr_valid !== 1'b0 || instr_out !== NOP) begin errors++; $display("FAIL killed_data got v=%0b i=%h exp v=0 i=%h", instr_valid, instr_out, NOP); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL refetch got req=%0b addr=%h exp req=1 addr=100", imem_req, imem_addr); end
  endtask

  task automatic test_flush_hold();
    imem_gnt = 1; step(); imem_gnt = 0;
    imem_rvalid = 1; imem_rdata = 32'h0000_0033; step(); imem_rvalid = 0;
    checks++; if (instr_valid !== 1'b1 || pc_out !== 32'h100) begin errors++; $display("FAIL hold2 got v=%0b pc=%h exp v=1 pc=100", instr_valid, pc_out); end
    flush = 1; instr_ready = 1; tgt = 32'h200; step(); flush = 0; instr_ready = 0;
    checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      errors++; $display("FAIL flush_hold got v=%0b req=%0b addr=%h exp v=0 req=1 addr=200", instr_valid, imem_req, imem_addr); end
    imem_gnt = 1; step(); imem_gnt = 0;
    checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h200) begin errors++; $display("FAIL one_req got req=%0b addr=%h exp req=0 addr=200", imem_req, imem_addr); end
    imem_rvalid = 1; imem_rdata = 32'h1234_5678; step(); imem_rvalid = 0;
    checks++; if (pc_out !== 32'h200 || instr_out !== 32'h1234_5678) begin errors++; $display("FAIL hold3 got pc=%h i=%h exp pc=200 i=12345678", pc_out, instr_out); end
    instr_ready = 1; step(); instr_ready = 0;
    checks++; if (imem_addr !== 32'h204) begin errors++; $display("FAIL post_flush_seq got %h exp 204", imem_addr); end
  endtask

  task automatic test_flush_req();
    flush = 1; tgt = 32'h300; step(); flush = 0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin errors++; $display("FAIL flush_req got req=%0b addr=%h exp req=1 addr=300", imem_req, imem_addr); end
    flush = 1; imem_gnt = 1; tgt = 32'h400; step(); flush = 0; imem_gnt = 0;
    checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h400) begin errors++; $display("FAIL flush_gnt got req=%0b addr=%h exp req=0 addr=400", imem_req, imem_addr); end
    imem_rvalid = 1; imem_rdata = 32'hCAFE_0001; step(); imem_rvalid = 0;
    checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h400) begin
      errors++; $display("FAIL flush_gnt_kill got v=%0b req=%0b addr=%h exp v=0 req=1 addr=400", instr_valid, imem_req, imem_addr); end
  endtask

  task automatic test_stray_rvalid();
    imem_rvalid = 1; imem_rdata = 32'hBAD0_BAD0; step(); imem_rvalid = 0;
    checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || instr_out !== NOP) begin
      errors++; $display("FAIL stray_rvalid got v=%0b req=%0b i=%h exp v=0 req=1 i=%h", instr_valid, imem_req, instr_out, NOP); end
  endtask

  task automatic test_wrap();
    flush = 1; tgt = 32'hFFFF_FFFC; step(); flush = 0;
    checks++; if (imem_addr !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap got addr=%h p4=%h exp addr=fffffffc p4=0", imem_addr, pc_plus4); end
    imem_gnt = 1; step(); imem_gnt = 0;
    imem_rvalid = 1; imem_rdata = 32'h0000_0013; step(); imem_rvalid = 0;
    checks++; if (pc_out !== 32'hFFFF_FFFC || instr_valid !== 1'b1) begin errors++; $display("FAIL wrap_hold got pc=%h v=%0b exp pc=fffffffc v=1", pc_out, instr_valid); end
    instr_ready = 1; step(); instr_ready = 0;
    checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin errors++; $display("FAIL wrap_next got addr=%h req=%0b exp addr=0 req=1", imem_addr, imem_req); end
  endtask

  task automatic test_misalign();
    flush = 1; tgt = 32'h102; step(); flush = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
    checks++; if (misalign_err !== 1'b1 || imem_req !== 1'b0 || imem_addr !== 32'h102) begin
      errors++; $display("FAIL misalign got err=%0b req=%0b addr=%h exp err=1 req=0 addr=102", misalign_err, imem_req, imem_addr); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (imem_req !== 1'b0 || misalign_err !== 1'b1 || instr_valid !== 1'b0) begin
        errors++; $display("FAIL err_hold_%0d got req=%0b err=%0b v=%0b exp req=0 err=1 v=0", i, imem_req, misalign_err, instr_valid); end
    end
    flush = 1; tgt = 32'h104; step(); flush = 0;
    checks++; if (misalign_err !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h104) begin
      errors++; $display("FAIL err_exit got err=%0b req=%0b addr=%h exp err=0 req=1 addr=104", misalign_err, imem_req, imem_addr); end
`else
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      errors++; $display("FAIL align_force got req=%0b addr=%h exp req=1 addr=100", imem_req, imem_addr); end
`endif
  endtask

  task automatic test_reset_mid_op();
    imem_gnt = 1; step(); imem_gnt = 0;
    rst_n = 0; #1;
    checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || instr_out !== NOP) begin
      errors++; $display("FAIL async_reset got req=%0b addr=%h i=%h exp req=0 addr=0 i=%h", imem_req, imem_addr, instr_out, NOP); end
    step(); rst_n = 1;
    imem_rvalid = 1; imem_rdata = 32'h5555_AAAA; step(); step(); imem_rvalid = 0;
    checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL late_rvalid got v=%0b req=%0b addr=%h exp v=0 req=1 addr=0", instr_valid, imem_req, imem_addr); end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_hold_stall();
    test_flush_wait();
    test_flush_hold();
    test_flush_req();
    test_stray_rvalid();
    test_wrap();
    test_misalign();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
